fifo_stream_reader: RTL and testbench

Read-side adapter for the window-buffer pixel FIFO. Pulls RGB pixels out of a `fifo` instance through its read/empty interface and presents them downstream as a valid/ready stream. Absorbs the one-cycle RAM read latency with a 3-entry output buffer. Tags each pixel with end-of-line and end-of-frame flags from internal column/row counters. Sits between the line FIFOs and the window/kernel stage.

---
 rtl/fifo_stream_reader.sv | 89 ++++++++
 tb/tb_fifo_stream_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side adapter: pulls pixels from the line FIFO, buffers them across the RAM
// read latency and presents a valid/ready stream tagged with end-of-line/frame flags.
module fifo_stream_reader #(
  parameter int COLOR_CHANNEL = 8,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  output logic                          o_fifo_read,
  input  logic                          i_fifo_empty,
  input  logic [2:0][COLOR_CHANNEL-1:0] i_fifo_read_value,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [2:0][COLOR_CHANNEL-1:0] o_pixel,
  output logic                          o_end_of_line,
  output logic                          o_end_of_frame
);

  localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

  typedef logic [2:0][COLOR_CHANNEL-1:0] pixel_t;

  pixel_t           buf_mem [0:2];
  logic [1:0]       head_ptr;
  logic [1:0]       tail_ptr;
  logic [1:0]       occupancy;
  logic             rd_vld_p1;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [2:0]       committed;
  logic             push;
  logic             pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Stage p0: read issue. Credit counts buffered pixels plus the one in flight,
  // so the buffer can never overflow even if downstream stalls indefinitely.
  assign committed   = {1'b0, occupancy} + {2'b00, rd_vld_p1};
  assign o_fifo_read = i_reset_n && !i_fifo_empty && (committed < 3'd3);

  assign push = rd_vld_p1;
  assign pop  = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rd_vld_p1 <= 1'b0;
      head_ptr  <= 2'd0;
      tail_ptr  <= 2'd0;
      occupancy <= 2'd0;
      col       <= '0;
      row       <= '0;
    end else begin
      rd_vld_p1 <= o_fifo_read;
      if (push) tail_ptr <= ptr_next(tail_ptr);
      if (pop)  head_ptr <= ptr_next(head_ptr);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
      if (pop) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // Stage p1: capture the FIFO read data one cycle after the strobe.
  always_ff @(posedge i_clk) begin
    if (push) buf_mem[tail_ptr] <= i_fifo_read_value;
  end

  // Stage p2: buffer head drives the output stream.
  assign o_valid        = (occupancy != 2'd0);
  assign o_pixel        = buf_mem[head_ptr];
  assign o_end_of_line  = o_valid && (col == COL_LAST);
  assign o_end_of_frame = o_end_of_line && (row == ROW_LAST);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO and stream model with directed
// and randomized traffic on a 4x2 image.
module tb_fifo_stream_reader;

  localparam int CC = 8;
  localparam int W  = 4;
  localparam int H  = 2;

  typedef logic [2:0][CC-1:0] pix_t;

  logic i_clk = 1'b0;
  logic i_reset_n;
  logic o_fifo_read;
  logic i_fifo_empty;
  pix_t fifo_rd_val;
  logic o_valid;
  logic i_ready;
  pix_t o_pixel;
  logic o_end_of_line;
  logic o_end_of_frame;

  pix_t fifo_q[$];
  pix_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   n = 0;
  int   delivered = 0;
  int   reads = 0;
  bit   last_read = 1'b0;
  bit   gap = 1'b0;
  bit   rd_seen = 1'b0;
  bit   stall_prev = 1'b0;
  pix_t prev_pix;

  fifo_stream_reader #(
    .COLOR_CHANNEL(CC),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .o_fifo_read      (o_fifo_read),
    .i_fifo_empty     (i_fifo_empty),
    .i_fifo_read_value(fifo_rd_val),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_pixel          (o_pixel),
    .o_end_of_line    (o_end_of_line),
    .o_end_of_frame   (o_end_of_frame)
  );

  always #5 i_clk = ~i_clk;

  // FIFO model: a read returns the head on the following cycle. Every pixel read
  // is owed downstream unless a reset discards it.
  always @(posedge i_clk) begin
    pix_t p;
    last_read = 1'b0;
    if (!i_reset_n) begin
      exp_q.delete();
    end else if (o_fifo_read && fifo_q.size() != 0) begin
      p = fifo_q.pop_front();
      fifo_rd_val <= p;
      exp_q.push_back(p);
      last_read = 1'b1;
      reads++;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input pix_t obs, input pix_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered at a falling edge with inputs already set.
  task automatic cyc();
    bit exp_valid;
    bit hs;
    i_fifo_empty = (fifo_q.size() == 0) || gap;
    #1;
    exp_valid = exp_q.size() > int'(last_read);
    rd_seen   = o_fifo_read;
    chk1("fifo_read", o_fifo_read, i_reset_n && !i_fifo_empty && (exp_q.size() < 3));
    chk1("outstanding_le3", exp_q.size() <= 3, 1'b1);
    chk1("valid", o_valid, exp_valid);
    if (exp_valid) begin
      chkp("pixel", o_pixel, exp_q[0]);
      chk1("eol", o_end_of_line, (n % W) == W - 1);
      chk1("eof", o_end_of_frame, (n % (W * H)) == W * H - 1);
    end else begin
      chk1("eol_idle", o_end_of_line, 1'b0);
      chk1("eof_idle", o_end_of_frame, 1'b0);
    end
    if (stall_prev) chkp("stall_stable", o_pixel, prev_pix);
    hs         = i_reset_n && o_valid && i_ready;
    stall_prev = i_reset_n && o_valid && !i_ready;
    prev_pix   = o_pixel;
    if (hs) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      n++;
      delivered++;
    end
    if (!i_reset_n) n = 0;
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    cyc();
    i_reset_n = 1'b1;
    chk1("rst_valid", o_valid, 1'b0);
    chk1("rst_eol", o_end_of_line, 1'b0);
    chk1("rst_eof", o_end_of_frame, 1'b0);
  endtask

  initial begin
    int   r0;
    int   d0;
    int   gen;
    int   k;
    int   first;
    pix_t p;

    i_reset_n    = 1'b0;
    i_ready      = 1'b0;
    i_fifo_empty = 1'b1;
    @(negedge i_clk);
    cyc();
    cyc();
    i_reset_n = 1'b1;

    // Idle with an empty FIFO
    repeat (10) begin
      cyc();
      chk1("idle_read", rd_seen, 1'b0);
      chk1("idle_valid", o_valid, 1'b0);
    end

    // Single pixel latency
    i_ready = 1'b1;
    fifo_q.push_back(24'h112233);
    cyc();
    chk1("sp_read_N", rd_seen, 1'b1);
    chk1("sp_valid_N1", o_valid, 1'b0);
    cyc();
    chk1("sp_valid_N2", o_valid, 1'b1);
    chkp("sp_pixel", o_pixel, 24'h112233);
    cyc();
    chk1("sp_valid_after", o_valid, 1'b0);

    // Streaming a full frame, then the start of the next one
    do_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back({8'(i), 8'(i), 8'(i)});
    cyc();
    cyc();
    for (int j = 0; j < 8; j++) begin
      chk1("stream_valid", o_valid, 1'b1);
      chkp("stream_pixel", o_pixel, {8'(j), 8'(j), 8'(j)});
      chk1("stream_eol", o_end_of_line, (j == 3) || (j == 7));
      chk1("stream_eof", o_end_of_frame, j == 7);
      cyc();
    end
    chk1("stream_done", o_valid, 1'b0);
    for (int i = 0; i < 4; i++) fifo_q.push_back({8'(8 + i), 8'(8 + i), 8'(8 + i)});
    cyc();
    cyc();
    for (int j = 0; j < 4; j++) begin
      chk1("f2_eol", o_end_of_line, j == 3);
      chk1("f2_eof", o_end_of_frame, 1'b0);
      cyc();
    end

    // Backpressure: only three reads may complete while stalled
    do_reset();
    i_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back({8'hA0 + 8'(i), 8'h55, 8'(i)});
    r0 = reads;
    repeat (10) cyc();
    chki("bp_reads", reads - r0, 3);
    chki("bp_fifo_left", fifo_q.size(), 3);
    chk1("bp_valid", o_valid, 1'b1);
    chkp("bp_head", o_pixel, {8'hA0, 8'h55, 8'h00});
    i_ready = 1'b1;
    d0 = delivered;
    for (int c = 0; c < 40 && delivered - d0 < 6; c++) cyc();
    chki("bp_delivered", delivered - d0, 6);

    // Random ready and FIFO empty gaps
    d0  = delivered;
    gen = 0;
    for (int c = 0; c < 20000 && delivered - d0 < 1000; c++) begin
      if (gen < 1000 && $urandom_range(0, 3) != 0) begin
        p = 24'($urandom);
        fifo_q.push_back(p);
        gen++;
      end
      gap     = ($urandom_range(0, 4) == 0);
      i_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    gap = 1'b0;
    chki("rand_delivered", delivered - d0, 1000);

    // Reset in the middle of a line with pixels buffered
    do_reset();
    i_ready = 1'b1;
    for (int i = 0; i < 6; i++) fifo_q.push_back({8'hC0 + 8'(i), 8'h0F, 8'(i)});
    d0 = delivered;
    for (int c = 0; c < 20 && delivered - d0 < 2; c++) cyc();
    chki("mr_two_out", delivered - d0, 2);
    i_ready = 1'b0;
    cyc();
    cyc();
    chk1("mr_valid_before", o_valid, 1'b1);
    i_reset_n = 1'b0;
    cyc();
    i_reset_n = 1'b1;
    chk1("mr_valid_after", o_valid, 1'b0);
    for (int i = 0; i < 8; i++) fifo_q.push_back({8'hE0 + 8'(i), 8'hF0, 8'(i)});
    i_ready = 1'b1;
    k = 0;
    first = -1;
    for (int c = 0; c < 40 && k < 6; c++) begin
      if (o_valid) begin
        if (o_end_of_line && first < 0) first = k;
        k++;
      end
      cyc();
    end
    chki("mr_first_eol", first, W - 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
